// File: rtl/log_pkg.sv
// log_pkg: shared FSM encoding and BlockRAM configuration constants for the log read-out path.
package log_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int RAM_DEPTH_DEFAULT = 32000;
    localparam int LOW_LATENCY       = 1;
    localparam int HIGH_PERFORMANCE  = 2;

    // Room for every read that can be in flight plus a two-word skid margin.
    function automatic int fifo_depth(input int latency);
        return latency + 2;
    endfunction

endpackage

// File: rtl/log_skid_fifo.sv
// log_skid_fifo: first-word-fall-through skid buffer with synchronous flush.
module log_skid_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && count != CW'(DEPTH);
    assign do_pop  = pop && count != '0;
    assign valid   = count != '0;
    assign head    = mem[rp];

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= inc(wp);
            if (do_pop) rp <= inc(rp);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock)
        if (do_push) mem[wp] <= push_data;

endmodule

// File: rtl/log_reader.sv
// log_reader: streams BlockRAM words 0..len-1 over a valid/ready handshake.
// Define LOG_READER_CHECKSUM_EN to append an XOR checksum word after the data.
module log_reader
    import log_pkg::*;
#(
    parameter int RAM_WIDTH    = 32,
    parameter int RAM_DEPTH    = RAM_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = LOW_LATENCY
) (
    input  logic                  clock,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_length,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_en,
    input  logic [RAM_WIDTH-1:0]  i_rd_data,
    output logic [RAM_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int DEPTH = fifo_depth(READ_LATENCY);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    state_t                  state, next;
    logic [ADDR_WIDTH-1:0]   len, len_in, issue;
    logic [ADDR_WIDTH:0]     acc, total;
    logic [READ_LATENCY-1:0] pipe;
    logic [CW-1:0]           inflight, occ;
    logic [RAM_WIDTH-1:0]    head;
    logic                    fifo_valid, start_ok, fire, pop;

    assign len_in    = i_length > ADDR_WIDTH'(RAM_DEPTH) ? ADDR_WIDTH'(RAM_DEPTH) : i_length;
    assign start_ok  = state == IDLE && i_start;
    assign fire      = o_valid && i_ready;
    // Issue only while every outstanding read is guaranteed a FIFO slot.
    assign o_rd_en   = state == RUN && ({1'b0, occ} + {1'b0, inflight}) < DEPTH_W;
    assign o_rd_addr = o_rd_en ? issue : '0;
    assign o_busy    = state == RUN || state == DRAIN;
    assign o_done    = state == DONE;

`ifdef LOG_READER_CHECKSUM_EN
    localparam state_t ZERO_NEXT = DRAIN;
    logic [RAM_WIDTH-1:0] csum;
    logic                 csum_phase;
    assign total      = {1'b0, len} + 1'b1;
    assign csum_phase = state == DRAIN && acc == {1'b0, len};
    assign o_valid    = fifo_valid || csum_phase;
    assign o_data     = fifo_valid ? head : csum_phase ? csum : '0;
    assign pop        = fire && fifo_valid;
    always_ff @(posedge clock)
        if (!i_reset_n || start_ok) csum <= '0;
        else if (pop) csum <= csum ^ head;
`else
    localparam state_t ZERO_NEXT = DONE;
    assign total   = {1'b0, len};
    assign o_valid = fifo_valid;
    assign o_data  = fifo_valid ? head : '0;
    assign pop     = fire;
`endif

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (i_start) next = len_in == '0 ? ZERO_NEXT : RUN;
            RUN:     if (o_rd_en && issue + 1'b1 == len) next = DRAIN;
            DRAIN:   if (acc + (ADDR_WIDTH + 1)'(fire) == total) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            len      <= '0;
            issue    <= '0;
            acc      <= '0;
            pipe     <= '0;
            inflight <= '0;
        end else begin
            state    <= next;
            pipe     <= READ_LATENCY'({pipe, o_rd_en});
            inflight <= inflight + CW'(o_rd_en) - CW'(pipe[READ_LATENCY-1]);
            if (start_ok) begin
                len   <= len_in;
                issue <= '0;
                acc   <= '0;
            end else begin
                issue <= issue + ADDR_WIDTH'(o_rd_en);
                acc   <= acc + (ADDR_WIDTH + 1)'(fire);
            end
        end
    end

    log_skid_fifo #(
        .WIDTH(RAM_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (i_reset_n),
        .flush    (start_ok),
        .push     (pipe[READ_LATENCY-1]),
        .push_data(i_rd_data),
        .pop      (pop),
        .head     (head),
        .valid    (fifo_valid),
        .count    (occ)
    );

endmodule

// File: doc/log_reader.md
# log_reader

Sequential read-out engine for the sample-logging BlockRAM; the counterpart of the logging write path. On a start pulse it walks the RAM read port from address 0 up to a requested word count and streams each word out over a valid/ready handshake with full backpressure support. It sits between the BlockRAM read port and the MicroBlaze-side consumer (GPIO/UART bridge), replacing per-word software address driving.

## Interface
- RAM_WIDTH, 32, data word width
- RAM_DEPTH, 32000, words in RAM; maximum read length
- ADDR_WIDTH, 16, read address width
- READ_LATENCY, 1, BlockRAM read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE)

- clock  in  1  single clock; all logic on posedge
- i_reset_n  in  1  reset, synchronous, active-low
- i_start  in  1  one-cycle start request
- i_length  in  ADDR_WIDTH  number of words to read
- o_rd_addr  out  ADDR_WIDTH  RAM read address
- o_rd_en  out  1  RAM read enable
- i_rd_data  in  RAM_WIDTH  RAM read data, valid READ_LATENCY cycles after o_rd_en
- o_data  out  RAM_WIDTH  stream data
- o_valid  out  1  stream data valid
- i_ready  in  1  consumer accepts o_data
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: i_start=1 latches len = min(i_length, RAM_DEPTH); issue counter, accept counter, and FIFO cleared; go to RUN, or to DONE if len=0.
- RUN: assert o_rd_en with o_rd_addr = issue counter when (FIFO occupancy + in-flight reads) < FIFO depth; increment issue counter per read. When issue counter reaches len, go to DRAIN.
- DRAIN: no reads; leave when accept counter reaches len (plus checksum word, see Configuration); go to DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=0; return to IDLE.
- Returned data is written into a skid FIFO READ_LATENCY cycles after each o_rd_en; o_valid = FIFO non-empty, o_data = FIFO head (first-word fall-through).
- Handshake: a word transfers on a cycle with o_valid & i_ready. Once o_valid rises, o_data holds stable until accepted. o_valid may not depend combinationally on i_ready.
- i_start outside IDLE is ignored.
- Addresses never exceed len-1; no wrap-around.
- Reset mid-transfer: next cycle state IDLE, FIFO flushed, in-flight returns discarded, no o_done.
- Reset values: o_rd_addr=0, o_rd_en=0, o_data=0, o_valid=0, o_busy=0, o_done=0.

## Timing
- Start sampled at edge 0; o_busy=1 and first o_rd_en (addr 0) in cycle 1.
- First o_valid in cycle 2+READ_LATENCY (cycle 3 for default).
- With i_ready held high: one word per cycle sustained, no bubbles after the first word.
- o_done in the cycle after the final accepted word; o_busy low in that same cycle.
- len=0: o_done in cycle 1, no o_rd_en, no o_valid.
- i_ready low indefinitely: reads stall once FIFO is full; no data lost or duplicated.

## Configuration
- LOG_READER_CHECKSUM_EN defined: after the last data word, one extra word = XOR of all len data words (0 when len=0, still sent) is emitted through the same handshake before o_done.
- Undefined: exactly len words, no checksum logic synthesised.

## Structure
- Shared package log_pkg: FSM state encoding, RAM_DEPTH default, READ_LATENCY encodings for LOW_LATENCY/HIGH_PERFORMANCE.
- One sub-module: log_skid_fifo (depth READ_LATENCY+2, FWFT, synchronous flush), instantiated once.

## Test plan
- RAM preloaded with word i = 0xA5000000+i, len=8, i_ready=1 -> o_data 0xA5000000..0xA5000007 on 8 consecutive cycles, first o_valid cycle 3, o_done cycle 11.
- len=16, i_ready toggling 1/0 every cycle -> all 16 words in order, none repeated, o_rd_en never issued with FIFO full.
- len=0 -> o_done in cycle 1, o_valid never asserted; with LOG_READER_CHECKSUM_EN one word 0x00000000 before o_done.
- len=40000 -> exactly 32000 words, last o_rd_addr=31999, no address wrap.
- i_reset_n low during word 5 of len=10 -> outputs at reset values next cycle, no o_done; new start with len=3 reads addresses 0,1,2.
- READ_LATENCY=2, len=4 words 1,2,4,8, LOG_READER_CHECKSUM_EN -> words 1,2,4,8 then 0x0000000F, then o_done.
